// File: rtl/flash_cache_loader.sv
// flash_cache_loader
// Boot-time loader: after a power-up wait it issues one SPI NOR READ (0x03)
// from FLASH_START_ADDRESS and streams the image continuously. Every 4 bytes
// are packed little-endian ({b3,b2,b1,b0}) and written to the cache. While the
// cache is busy, the SPI clock is frozen low with chip select still asserted.
// The flash therefore resumes the same stream without being re-addressed.
//
// Optional build macro: FLASH_CACHE_LOADER_CHECKSUM_EN
//   defined   -> checksum accumulates every written word (mod 2^32)
//   undefined -> checksum is tied to 0 and no adder is built
//
// Ports:
//   clk                 system clock, rising edge
//   rst                 asynchronous active-high reset
//   flash_clk           SPI clock (mode 0, idles low, 2 clk cycles per bit)
//   flash_mosi          SPI data to flash, MSB first
//   flash_miso          SPI data from flash, sampled at the end of the high phase
//   flash_cs            SPI chip select, active-low
//   cache_address       byte address of the current word (wraps mod 2^32)
//   cache_data_in       packed word being assembled / written
//   cache_write_enable  4'b1111 while a write is outstanding, else 0
//   cache_busy          cache busy flag, only looked at while writing
//   busy                high from reset release until the image is copied
//   done                sticky completion flag
//   checksum            running sum of written words (optional feature)

module flash_cache_loader #(
  parameter int unsigned STARTUP_WAIT        = 1_000_000,
  parameter logic [23:0] FLASH_START_ADDRESS = 24'h00_0000,
  parameter logic [31:0] TRANSFER_BYTES      = 32'h0020_0000,
  parameter logic [31:0] CACHE_BASE_ADDRESS  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_cs,
  output logic [31:0] cache_address,
  output logic [31:0] cache_data_in,
  output logic [3:0]  cache_write_enable,
  input  logic        cache_busy,
  output logic        busy,
  output logic        done,
  output logic [31:0] checksum
);

  typedef enum logic [2:0] {
    S_WAIT_POWER,
    S_SEND_CMD,
    S_SEND_ADDR,
    S_READ,
    S_WRITE_WAIT,
    S_FINISH,
    S_DONE
  } state_t;

  // Command byte and address are shifted out as one 32-bit MSB-first word.
  localparam logic [31:0] CMD_ADDR = {8'h03, FLASH_START_ADDRESS};

  state_t      state_q;
  state_t      state_d;
  logic [31:0] wait_cnt;
  logic        ph;         // 0 = SPI low phase, 1 = SPI high phase
  logic [4:0]  bit_cnt;    // bit index within command+address, or within the word
  logic        wr_first;   // first cycle of a cache write, cache_busy ignored
  logic [31:0] byte_cnt;   // bytes already committed to the cache
  logic        spi_active;
  logic        bit_end;
  logic        wr_done;
  logic        last_word;
  logic [4:0]  lane_lsb;

  assign spi_active = (state_q == S_SEND_CMD) || (state_q == S_SEND_ADDR) ||
                      (state_q == S_READ);
  assign bit_end    = spi_active && ph;
  assign wr_done    = (state_q == S_WRITE_WAIT) && !wr_first && !cache_busy;
  assign last_word  = ((byte_cnt + 32'd4) == TRANSFER_BYTES);
  // Byte k of the word lands in lane k; bit_cnt[4:3] is the byte index.
  assign lane_lsb   = {bit_cnt[4:3], 3'b000};

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_WAIT_POWER;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_WAIT_POWER: if (wait_cnt == STARTUP_WAIT) state_d = S_SEND_CMD;
      S_SEND_CMD:   if (bit_end && (bit_cnt == 5'd7)) state_d = S_SEND_ADDR;
      S_SEND_ADDR:  if (bit_end && (bit_cnt == 5'd31)) state_d = S_READ;
      S_READ:       if (bit_end && (bit_cnt == 5'd31)) state_d = S_WRITE_WAIT;
      S_WRITE_WAIT: if (wr_done) state_d = last_word ? S_FINISH : S_READ;
      S_FINISH:     state_d = S_DONE;
      S_DONE:       state_d = S_DONE;
      default:      state_d = S_WAIT_POWER;
    endcase
  end

  // Output decode: everything the flash and cache see follows the state and
  // bit position directly, so reset values appear as soon as rst is asserted.
  always_comb begin
    flash_clk          = spi_active && ph;
    flash_mosi         = 1'b0;
    flash_cs           = 1'b1;
    cache_write_enable = 4'b0000;
    busy               = (state_q != S_DONE);
    done               = (state_q == S_DONE);
    if ((state_q == S_SEND_CMD) || (state_q == S_SEND_ADDR)) begin
      flash_mosi = CMD_ADDR[~bit_cnt];
    end
    if (spi_active || (state_q == S_WRITE_WAIT) || (state_q == S_FINISH)) begin
      flash_cs = 1'b0;
    end
    if (state_q == S_WRITE_WAIT) begin
      cache_write_enable = 4'b1111;
    end
  end

  // Counters, word assembly and cache address
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt      <= '0;
      ph            <= 1'b0;
      bit_cnt       <= '0;
      wr_first      <= 1'b0;
      byte_cnt      <= '0;
      cache_address <= CACHE_BASE_ADDRESS;
      cache_data_in <= '0;
    end else begin
      if ((state_q == S_WAIT_POWER) && (wait_cnt != STARTUP_WAIT)) begin
        wait_cnt <= wait_cnt + 32'd1;
      end
      // Phase toggles only while shifting; leaving READ parks it in the low phase.
      ph <= spi_active && !ph;
      if (bit_end) begin
        bit_cnt <= bit_cnt + 5'd1;
      end
      if ((state_q == S_READ) && ph) begin
        cache_data_in[lane_lsb +: 8] <= {cache_data_in[lane_lsb +: 7], flash_miso};
      end
      // READ only ever exits into WRITE_WAIT, so this marks its first cycle.
      wr_first <= (state_q == S_READ);
      if (wr_done) begin
        cache_address <= cache_address + 32'd4;
        byte_cnt      <= byte_cnt + 32'd4;
      end
    end
  end

`ifdef FLASH_CACHE_LOADER_CHECKSUM_EN
  // Checksum accumulates in the completion cycle of each write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      checksum <= '0;
    end else if (wr_done) begin
      checksum <= checksum + cache_data_in;
    end
  end
`else
  assign checksum = '0;
`endif

endmodule
